udp_oe_arp_tx: RTL and testbench

//  Consumes the single-cycle arp_trigger from the UDP offload engine RX decoder and emits one ARP reply

---
 rtl/udp_oe_pkg.sv | 43 ++++
 rtl/udp_oe_arp_tx.sv | 130 +++++++++++++
 tb/tb_udp_oe_arp_tx.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_oe_pkg.sv
// rtl/udp_oe_pkg.sv - shared constants, types and the ARP reply beat builder for the UDP offload engine
package udp_oe_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'h06;
    localparam logic [7:0]  ARP_PLEN       = 8'h04;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

    localparam int ETH_MIN_FRAME_BYTES = 60;
    localparam int ARP_FRAME_BYTES     = 42;

    typedef enum logic [1:0] {
        ARP_TX_IDLE = 2'd0,
        ARP_TX_SEND = 2'd1,
        ARP_TX_GAP  = 2'd2
    } arp_tx_state_e;

    typedef struct packed {
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_snapshot_t;

    // Beats 6 and 7 only exist when padding to the Ethernet minimum and carry zeros.
    function automatic logic [63:0] arp_reply_beat(input logic [2:0] idx, input arp_snapshot_t snap);
        logic [63:0] beat;
        beat = '0;
        case (idx)
            3'd0:    beat = {snap.tha, snap.sha[47:32]};
            3'd1:    beat = {snap.sha[31:0], ETHERTYPE_ARP, ARP_HTYPE_ETH};
            3'd2:    beat = {ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN, ARP_OPER_REPLY, snap.sha[47:32]};
            3'd3:    beat = {snap.sha[31:0], snap.spa};
            3'd4:    beat = {snap.tha, snap.tpa[31:16]};
            3'd5:    beat = {snap.tpa[15:0], 48'h0};
            default: beat = '0;
        endcase
        return beat;
    endfunction

endpackage

// File: rtl/udp_oe_arp_tx.sv
// rtl/udp_oe_arp_tx.sv - ARP reply frame generator emitting 64-bit stream beats toward the TX frame mux
module udp_oe_arp_tx
    import udp_oe_pkg::*;
#(
    parameter bit          PAD_TO_MIN = 1'b1,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arp_enable,
    input  logic             arp_trigger,
    input  logic [47:0]      fpga_mac_adr,
    input  logic [31:0]      fpga_ip_adr,
    input  logic [47:0]      host_mac_adr,
    input  logic [31:0]      host_ip_adr,
    output logic             tx_tvalid,
    input  logic             tx_tready,
    output logic [63:0]      tx_tdata,
    output logic [7:0]       tx_tkeep,
    output logic             tx_tlast,
    output logic [CNT_W-1:0] arp_tx_count,
    output logic [CNT_W-1:0] arp_drop_count,
    output logic             busy
);

    localparam int         FRAME_BYTES = PAD_TO_MIN ? ETH_MIN_FRAME_BYTES : ARP_FRAME_BYTES;
    localparam int         NUM_BEATS   = (FRAME_BYTES + 7) / 8;
    localparam logic [2:0] LAST_BEAT   = 3'(NUM_BEATS - 1);
    localparam int         LAST_BYTES  = FRAME_BYTES - 8 * (NUM_BEATS - 1);
    localparam logic [7:0] LAST_KEEP   = ~(8'hFF >> LAST_BYTES);
    localparam bit         HAS_GAP     = (GAP_CYCLES > 0);
    localparam logic [7:0] GAP_LAST    = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arp_tx_state_e    state_q, state_d;
    logic [2:0]       beat_q, beat_d;
    logic [7:0]       gap_q, gap_d;
    logic             pending_q, pending_d;
    arp_snapshot_t    snap_q, snap_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic trig;
    logic accept;
    logic gap_done;
    logic start;

    always_comb begin
        trig     = arp_enable & arp_trigger;
        accept   = (state_q == ARP_TX_SEND) & tx_tready;
        gap_done = (state_q == ARP_TX_GAP) & (gap_q == GAP_LAST);
        // The last gap cycle may launch the queued frame directly, so the
        // forced idle time between tlast and the next beat0 is exactly GAP_CYCLES.
        start    = ((state_q == ARP_TX_IDLE) | gap_done) & (trig | pending_q);

        state_d    = state_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        pending_d  = pending_q;
        snap_d     = snap_q;
        tx_cnt_d   = tx_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            ARP_TX_IDLE: ;
            ARP_TX_SEND: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        tx_cnt_d = tx_cnt_q + CNT_ONE;
                        gap_d    = 8'd0;
                        state_d  = HAS_GAP ? ARP_TX_GAP : ARP_TX_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            ARP_TX_GAP: begin
                if (gap_done) state_d = ARP_TX_IDLE;
                else          gap_d   = gap_q + 8'd1;
            end
            default: state_d = ARP_TX_IDLE;
        endcase

        if (start) begin
            state_d = ARP_TX_SEND;
            beat_d  = 3'd0;
            snap_d  = '{sha: fpga_mac_adr, spa: fpga_ip_adr, tha: host_mac_adr, tpa: host_ip_adr};
        end

        // A trigger arriving as the pending request is consumed takes its place.
        if (start) begin
            pending_d = pending_q & trig;
        end else if (trig) begin
            if (pending_q) drop_cnt_d = drop_cnt_q + CNT_ONE;
            else           pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARP_TX_IDLE;
            beat_q     <= 3'd0;
            gap_q      <= 8'd0;
            pending_q  <= 1'b0;
            snap_q     <= '0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            snap_q     <= snap_d;
            tx_cnt_q   <= tx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        tx_tvalid      = (state_q == ARP_TX_SEND);
        tx_tlast       = tx_tvalid & (beat_q == LAST_BEAT);
        tx_tdata       = tx_tvalid ? arp_reply_beat(beat_q, snap_q) : 64'h0;
        tx_tkeep       = tx_tvalid ? (tx_tlast ? LAST_KEEP : 8'hFF) : 8'h00;
        arp_tx_count   = tx_cnt_q;
        arp_drop_count = drop_cnt_q;
        busy           = (state_q != ARP_TX_IDLE) | pending_q;
    end

endmodule

// File: tb/tb_udp_oe_arp_tx.sv
// tb/tb_udp_oe_arp_tx.sv - self-checking bench for udp_oe_arp_tx against a byte-level ARP frame model
`timescale 1ns/1ps
module tb_udp_oe_arp_tx;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arp_enable = 1'b1;
    logic        trg0 = 1'b0, trg1 = 1'b0, trg2 = 1'b0;
    logic        rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
    logic [47:0] fmac = 48'h0011_2233_4455;
    logic [31:0] fip  = 32'hC0A8_0102;
    logic [47:0] hmac = 48'hAABB_CCDD_EEFF;
    logic [31:0] hip  = 32'hC0A8_0101;

    logic        tv0, tl0, bz0, tv1, tl1, bz1, tv2, tl2, bz2;
    logic [63:0] td0, td1, td2;
    logic [7:0]  tk0, tk1, tk2;
    logic [15:0] cnt0, drp0, cnt1, drp1, cnt2, drp2;

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int exp_cnt0 = 0;
    int exp_drp0 = 0;

    beat_t q0[$], q1[$], q2[$];
    int    s0[$], s1[$], s2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    udp_oe_arp_tx u0 (
        .clk(clk), .reset(reset), .arp_enable(arp_enable), .arp_trigger(trg0),
        .fpga_mac_adr(fmac), .fpga_ip_adr(fip), .host_mac_adr(hmac), .host_ip_adr(hip),
        .tx_tvalid(tv0), .tx_tready(rdy0), .tx_tdata(td0), .tx_tkeep(tk0), .tx_tlast(tl0),
        .arp_tx_count(cnt0), .arp_drop_count(drp0), .busy(bz0)
    );

    udp_oe_arp_tx #(.GAP_CYCLES(4)) u1 (
        .clk(clk), .reset(reset), .arp_enable(arp_enable), .arp_trigger(trg1),
        .fpga_mac_adr(fmac), .fpga_ip_adr(fip), .host_mac_adr(hmac), .host_ip_adr(hip),
        .tx_tvalid(tv1), .tx_tready(rdy1), .tx_tdata(td1), .tx_tkeep(tk1), .tx_tlast(tl1),
        .arp_tx_count(cnt1), .arp_drop_count(drp1), .busy(bz1)
    );

    udp_oe_arp_tx #(.PAD_TO_MIN(1'b0)) u2 (
        .clk(clk), .reset(reset), .arp_enable(arp_enable), .arp_trigger(trg2),
        .fpga_mac_adr(fmac), .fpga_ip_adr(fip), .host_mac_adr(hmac), .host_ip_adr(hip),
        .tx_tvalid(tv2), .tx_tready(rdy2), .tx_tdata(td2), .tx_tkeep(tk2), .tx_tlast(tl2),
        .arp_tx_count(cnt2), .arp_drop_count(drp2), .busy(bz2)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (tv0 && rdy0) begin q0.push_back({td0, tk0, tl0}); s0.push_back(cyc); end
            if (tv1 && rdy1) begin q1.push_back({td1, tk1, tl1}); s1.push_back(cyc); end
            if (tv2 && rdy2) begin q2.push_back({td2, tk2, tl2}); s2.push_back(cyc); end
        end
    end

    // Reference: lay the ARP reply out as wire bytes, pad, then cut into 8-byte beats.
    task automatic build_frame(input bit pad, input logic [47:0] sha, input logic [31:0] spa,
                               input logic [47:0] tha, input logic [31:0] tpa,
                               output beat_t b [0:7], output int n);
        byte unsigned f[$];
        for (int j = 5; j >= 0; j--) f.push_back(tha[8*j +: 8]);
        for (int j = 5; j >= 0; j--) f.push_back(sha[8*j +: 8]);
        f.push_back(8'h08); f.push_back(8'h06);
        f.push_back(8'h00); f.push_back(8'h01);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h06); f.push_back(8'h04);
        f.push_back(8'h00); f.push_back(8'h02);
        for (int j = 5; j >= 0; j--) f.push_back(sha[8*j +: 8]);
        for (int j = 3; j >= 0; j--) f.push_back(spa[8*j +: 8]);
        for (int j = 5; j >= 0; j--) f.push_back(tha[8*j +: 8]);
        for (int j = 3; j >= 0; j--) f.push_back(tpa[8*j +: 8]);
        while (pad && f.size() < 60) f.push_back(8'h00);
        n = (f.size() + 7) / 8;
        for (int i = 0; i < 8; i++) begin
            b[i] = '0;
            for (int j = 0; j < 8; j++) begin
                if (8*i + j < f.size()) begin
                    b[i].d[63-8*j -: 8] = f[8*i + j];
                    b[i].k[7-j] = 1'b1;
                end
            end
            b[i].l = (i == n - 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q0.delete(); q1.delete(); q2.delete();
        s0.delete(); s1.delete(); s2.delete();
    endtask

    function automatic int qsize(input int w);
        case (w)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic wait_q(input int w, input int n, input int maxc, output bit ok);
        int c = 0;
        while (qsize(w) < n && c < maxc) begin
            tick();
            c++;
        end
        ok = (qsize(w) >= n);
    endtask

    task automatic pulse(input int w, output int k);
        case (w)
            0:       trg0 = 1'b1;
            1:       trg1 = 1'b1;
            default: trg2 = 1'b1;
        endcase
        k = cyc;
        tick();
        trg0 = 1'b0; trg1 = 1'b0; trg2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        vec++; if (tv0 !== 1'b0 || tl0 !== 1'b0) begin miss++; $display("FAIL reset_valid got %b/%b want 0/0", tv0, tl0); end
        vec++; if (td0 !== 64'h0 || tk0 !== 8'h0) begin miss++; $display("FAIL reset_data got %h/%h want 0/0", td0, tk0); end
        vec++; if (cnt0 !== 16'h0) begin miss++; $display("FAIL reset_count got %h want 0", cnt0); end
        vec++; if (drp0 !== 16'h0) begin miss++; $display("FAIL reset_drop got %h want 0", drp0); end
        vec++; if (bz0 !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", bz0); end
        vec++; if ({tv1, tv2, bz1, bz2, cnt1, cnt2} !== '0) begin miss++; $display("FAIL reset_others got %b%b%b%b want 0", tv1, tv2, bz1, bz2); end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        beat_t e [0:7];
        beat_t b0, b3, b7;
        int n, k;
        bit ok;
        rdy0 = 1'b1;
        clear_q();
        pulse(0, k);
        wait_q(0, 8, 40, ok);
        tick(); tick();
        build_frame(1'b1, fmac, fip, hmac, hip, e, n);
        vec++; if (!ok || q0.size() != 8) begin miss++; $display("FAIL single_beats got %0d want 8", q0.size()); end
        for (int i = 0; i < q0.size() && i < 8; i++) begin
            vec++;
            if (q0[i] !== e[i] || s0[i] != k + 1 + i) begin
                miss++; $display("FAIL single_beat[%0d] got %h@%0d want %h@%0d", i, q0[i], s0[i], e[i], k + 1 + i);
            end
        end
        b0 = (q0.size() > 0) ? q0[0] : '0;
        b3 = (q0.size() > 3) ? q0[3] : '0;
        b7 = (q0.size() > 7) ? q0[7] : '0;
        vec++; if (b0.d !== 64'hAABBCCDDEEFF0011) begin miss++; $display("FAIL single_b0 got %h want aabbccddeeff0011", b0.d); end
        vec++; if (b3.d !== 64'h22334455C0A80102) begin miss++; $display("FAIL single_b3 got %h want 22334455c0a80102", b3.d); end
        vec++; if (b7.k !== 8'hF0 || b7.l !== 1'b1) begin miss++; $display("FAIL single_b7_keep got %h/%b want f0/1", b7.k, b7.l); end
        exp_cnt0++;
        vec++; if (cnt0 != exp_cnt0) begin miss++; $display("FAIL single_count got %0d want %0d", cnt0, exp_cnt0); end
        vec++; if (bz0 !== 1'b0) begin miss++; $display("FAIL single_busy got %b want 0", bz0); end
    endtask

    task automatic test_stall();
        beat_t e [0:7];
        beat_t held, cur;
        bit hv = 1'b0;
        int n, k;
        clear_q();
        pulse(0, k);
        for (int j = 0; j < 20; j++) begin
            rdy0 = (j % 2 == 0);
            @(negedge clk);
            cur = {td0, tk0, tl0};
            if (hv) begin
                vec++;
                if (tv0 !== 1'b1 || cur !== held) begin
                    miss++; $display("FAIL stall_hold got %b/%h want 1/%h", tv0, cur, held);
                end
            end
            hv = tv0 && !rdy0;
            held = cur;
            tick();
        end
        rdy0 = 1'b1;
        build_frame(1'b1, fmac, fip, hmac, hip, e, n);
        vec++; if (q0.size() != 8) begin miss++; $display("FAIL stall_beats got %0d want 8", q0.size()); end
        for (int i = 0; i < q0.size() && i < 8; i++) begin
            vec++;
            if (q0[i] !== e[i] || s0[i] != k + 1 + 2*i) begin
                miss++; $display("FAIL stall_beat[%0d] got %h@%0d want %h@%0d", i, q0[i], s0[i], e[i], k + 1 + 2*i);
            end
        end
        exp_cnt0++;
        vec++; if (cnt0 != exp_cnt0) begin miss++; $display("FAIL stall_count got %0d want %0d", cnt0, exp_cnt0); end
    endtask

    task automatic test_back_to_back();
        beat_t e [0:7];
        int n, k, kx;
        bit ok;
        rdy0 = 1'b1;
        clear_q();
        pulse(0, k);
        tick();
        pulse(0, kx);
        tick();
        pulse(0, kx);
        while (cyc < k + 9) tick();
        pulse(0, kx);
        wait_q(0, 24, 80, ok);
        vec++; if (bz0 !== 1'b0) begin miss++; $display("FAIL b2b_busy_after_tlast got %b want 0", bz0); end
        repeat (12) tick();
        build_frame(1'b1, fmac, fip, hmac, hip, e, n);
        vec++; if (!ok || q0.size() != 24) begin miss++; $display("FAIL b2b_beats got %0d want 24", q0.size()); end
        for (int i = 0; i < q0.size() && i < 24; i++) begin
            vec++;
            if (q0[i] !== e[i % 8]) begin miss++; $display("FAIL b2b_beat[%0d] got %h want %h", i, q0[i], e[i % 8]); end
        end
        if (q0.size() == 24) begin
            vec++; if (s0[8] - s0[7] != 2 || s0[16] - s0[15] != 2) begin
                miss++; $display("FAIL b2b_spacing got %0d/%0d want 2/2", s0[8] - s0[7], s0[16] - s0[15]);
            end
        end
        exp_cnt0 += 3;
        exp_drp0 += 1;
        vec++; if (cnt0 != exp_cnt0) begin miss++; $display("FAIL b2b_count got %0d want %0d", cnt0, exp_cnt0); end
        vec++; if (drp0 != exp_drp0) begin miss++; $display("FAIL b2b_drop got %0d want %0d", drp0, exp_drp0); end
    endtask

    task automatic test_enable();
        int k;
        bit ok;
        rdy0 = 1'b1;
        clear_q();
        arp_enable = 1'b0;
        pulse(0, k);
        repeat (12) tick();
        vec++; if (q0.size() != 0 || bz0 !== 1'b0) begin miss++; $display("FAIL enable_off got %0d beats busy %b want 0/0", q0.size(), bz0); end
        arp_enable = 1'b1;
        pulse(0, k);
        tick(); tick();
        arp_enable = 1'b0;
        pulse(0, k);
        wait_q(0, 8, 40, ok);
        repeat (12) tick();
        arp_enable = 1'b1;
        vec++; if (!ok || q0.size() != 8) begin miss++; $display("FAIL enable_inflight got %0d beats want 8", q0.size()); end
        exp_cnt0++;
        vec++; if (cnt0 != exp_cnt0 || drp0 != exp_drp0) begin
            miss++; $display("FAIL enable_counts got %0d/%0d want %0d/%0d", cnt0, drp0, exp_cnt0, exp_drp0);
        end
    endtask

    task automatic test_snapshot();
        beat_t e [0:7];
        int n, k;
        bit ok;
        logic [47:0] om, hm;
        logic [31:0] oi, hi;
        om = fmac; oi = fip; hm = hmac; hi = hip;
        rdy0 = 1'b1;
        clear_q();
        pulse(0, k);
        tick();
        fmac = {16'($urandom()), $urandom()};
        fip  = $urandom();
        hmac = {16'($urandom()), $urandom()};
        hip  = $urandom();
        wait_q(0, 8, 40, ok);
        tick(); tick();
        build_frame(1'b1, om, oi, hm, hi, e, n);
        vec++; if (!ok) begin miss++; $display("FAIL snapshot_timeout got %0d beats want 8", q0.size()); end
        for (int i = 0; i < q0.size() && i < 8; i++) begin
            vec++;
            if (q0[i] !== e[i]) begin miss++; $display("FAIL snapshot_beat[%0d] got %h want %h", i, q0[i], e[i]); end
        end
        exp_cnt0++;
    endtask

    task automatic test_random();
        beat_t e [0:7];
        int n, k, c;
        for (int it = 0; it < 6; it++) begin
            fmac = {16'($urandom()), $urandom()};
            fip  = $urandom();
            hmac = {16'($urandom()), $urandom()};
            hip  = $urandom();
            clear_q();
            pulse(0, k);
            c = 0;
            while (q0.size() < 8 && c < 200) begin
                rdy0 = 1'($urandom_range(0, 1));
                tick();
                c++;
            end
            rdy0 = 1'b1;
            tick(); tick();
            build_frame(1'b1, fmac, fip, hmac, hip, e, n);
            vec++; if (q0.size() != 8) begin miss++; $display("FAIL random%0d_beats got %0d want 8", it, q0.size()); end
            for (int i = 0; i < q0.size() && i < 8; i++) begin
                vec++;
                if (q0[i] !== e[i]) begin miss++; $display("FAIL random%0d_beat[%0d] got %h want %h", it, i, q0[i], e[i]); end
            end
            exp_cnt0++;
        end
        vec++; if (cnt0 != exp_cnt0) begin miss++; $display("FAIL random_count got %0d want %0d", cnt0, exp_cnt0); end
    endtask

    task automatic test_gap();
        beat_t e [0:7];
        int n, k, kx;
        bit ok;
        rdy1 = 1'b1;
        clear_q();
        pulse(1, k);
        tick();
        pulse(1, kx);
        wait_q(1, 16, 80, ok);
        repeat (8) tick();
        build_frame(1'b1, fmac, fip, hmac, hip, e, n);
        vec++; if (!ok || q1.size() != 16) begin miss++; $display("FAIL gap_beats got %0d want 16", q1.size()); end
        for (int i = 0; i < q1.size() && i < 16; i++) begin
            vec++;
            if (q1[i] !== e[i % 8]) begin miss++; $display("FAIL gap_beat[%0d] got %h want %h", i, q1[i], e[i % 8]); end
        end
        if (q1.size() == 16) begin
            vec++; if (s1[0] != k + 1) begin miss++; $display("FAIL gap_first_latency got %0d want %0d", s1[0], k + 1); end
            vec++; if (s1[8] - s1[7] - 1 != 4) begin miss++; $display("FAIL gap_idle_cycles got %0d want 4", s1[8] - s1[7] - 1); end
        end
        vec++; if (cnt1 != 2 || drp1 != 0 || bz1 !== 1'b0) begin
            miss++; $display("FAIL gap_counts got %0d/%0d/%b want 2/0/0", cnt1, drp1, bz1);
        end
    endtask

    task automatic test_nopad();
        beat_t e [0:7];
        beat_t b5;
        int n, k;
        bit ok;
        rdy2 = 1'b1;
        clear_q();
        pulse(2, k);
        wait_q(2, 6, 40, ok);
        repeat (6) tick();
        build_frame(1'b0, fmac, fip, hmac, hip, e, n);
        vec++; if (!ok || q2.size() != 6 || n != 6) begin miss++; $display("FAIL nopad_beats got %0d want 6", q2.size()); end
        for (int i = 0; i < q2.size() && i < 6; i++) begin
            vec++;
            if (q2[i] !== e[i]) begin miss++; $display("FAIL nopad_beat[%0d] got %h want %h", i, q2[i], e[i]); end
        end
        b5 = (q2.size() > 5) ? q2[5] : '0;
        vec++; if (b5.d !== {hip[15:0], 48'h0} || b5.k !== 8'hC0 || b5.l !== 1'b1) begin
            miss++; $display("FAIL nopad_last got %h/%h/%b want %h/c0/1", b5.d, b5.k, b5.l, {hip[15:0], 48'h0});
        end
        vec++; if (cnt2 != 1) begin miss++; $display("FAIL nopad_count got %0d want 1", cnt2); end
    endtask

    task automatic test_reset_midframe();
        beat_t e [0:7];
        int n, k;
        bit ok;
        rdy0 = 1'b1;
        clear_q();
        build_frame(1'b1, fmac, fip, hmac, hip, e, n);
        pulse(0, k);
        wait_q(0, 3, 40, ok);
        vec++; if (!ok || tv0 !== 1'b1 || td0 !== e[3].d) begin
            miss++; $display("FAIL midreset_pre got %b/%h want 1/%h", tv0, td0, e[3].d);
        end
        #2;
        reset = 1'b1;
        #1;
        vec++; if (tv0 !== 1'b0 || bz0 !== 1'b0) begin miss++; $display("FAIL midreset_async got %b/%b want 0/0", tv0, bz0); end
        vec++; if (cnt0 !== 16'h0 || drp0 !== 16'h0) begin miss++; $display("FAIL midreset_counts got %0d/%0d want 0/0", cnt0, drp0); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        exp_cnt0 = 0;
        exp_drp0 = 0;
        clear_q();
        pulse(0, k);
        wait_q(0, 8, 40, ok);
        tick(); tick();
        vec++; if (!ok || q0.size() != 8) begin miss++; $display("FAIL midreset_restart got %0d beats want 8", q0.size()); end
        for (int i = 0; i < q0.size() && i < 8; i++) begin
            vec++;
            if (q0[i] !== e[i] || s0[i] != k + 1 + i) begin
                miss++; $display("FAIL midreset_beat[%0d] got %h@%0d want %h@%0d", i, q0[i], s0[i], e[i], k + 1 + i);
            end
        end
        exp_cnt0++;
        vec++; if (cnt0 != exp_cnt0) begin miss++; $display("FAIL midreset_count got %0d want %0d", cnt0, exp_cnt0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_enable();
        test_snapshot();
        test_random();
        test_gap();
        test_nopad();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
